video_timing_gen: RTL and testbench

Parametrised successor to the pixel frame counter. It generates the full raster, active area plus front porch, sync and back porch, in both axes. It drives hsync/vsync with configurable polarity, a data-enable, a vertical-blank level and single-cycle line/frame strobes. It sits between the pixel-clock enable and the VGA/framebuffer read logic, so downstream consumers need no decode of their own.

---
 rtl/video_timing_gen_if.sv | 36 +++
 rtl/video_timing_gen.sv | 127 ++++++++++++
 tb/tb_video_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Pixel-tick controls and raster timing outputs of the
//               video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          en_i;
    logic          sync_clr_i;
    logic [CW-1:0] hcount_o;
    logic [CW-1:0] vcount_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          de_o;
    logic          vblank_o;
    logic          line_start_o;
    logic          frame_start_o;
    logic          frame_end_o;

    // The generator owns the raster; consumers supply the pixel tick.
    modport master (
        input  en_i, sync_clr_i,
        output hcount_o, vcount_o, hsync_o, vsync_o, de_o, vblank_o,
               line_start_o, frame_start_o, frame_end_o
    );

    modport slave (
        output en_i, sync_clr_i,
        input  hcount_o, vcount_o, hsync_o, vsync_o, de_o, vblank_o,
               line_start_o, frame_start_o, frame_end_o
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator (active, porches, sync)
//               with registered syncs, data-enable, vblank and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    video_timing_gen_if.master  vt
);
    localparam int c_H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_MAX_TOT = (c_H_TOT > c_V_TOT) ? c_H_TOT : c_V_TOT;

    localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOT - 1);
    localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOT - 1);
    localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] c_VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] c_FE_H     = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] c_FE_V     = CW'(V_ACTIVE - 1);

    generate
        if ((2 ** CW) <= (c_MAX_TOT - 1)) begin : g_err_cw
            $error("video_timing_gen: CW too narrow for raster totals");
        end
        if ((H_ACTIVE < 1) || (H_SYNC < 1) || (V_ACTIVE < 1) || (V_SYNC < 1) ||
            (H_FP < 0) || (H_BP < 0) || (V_FP < 0) || (V_BP < 0)) begin : g_err_seg
            $error("video_timing_gen: illegal segment length");
        end
    endgenerate

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_vblank;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_frame_end;

    logic          w_h_wrap;
    logic [CW-1:0] w_hnext;
    logic [CW-1:0] w_vnext;
    logic          w_hs_region;
    logic          w_vs_region;

    // Level outputs are decoded from the next counts so they land with them.
    always_comb begin
        w_h_wrap = (r_hcount == c_H_LAST);
        w_hnext  = w_h_wrap ? '0 : r_hcount + CW'(1);
        w_vnext  = r_vcount;
        if (w_h_wrap) begin
            w_vnext = (r_vcount == c_V_LAST) ? '0 : r_vcount + CW'(1);
        end
        w_hs_region = (w_hnext >= c_HS_BEG) && (w_hnext <= c_HS_LAST);
        w_vs_region = (w_vnext >= c_VS_BEG) && (w_vnext <= c_VS_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hcount      <= c_H_LAST;
            r_vcount      <= c_V_LAST;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_vblank      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else if (vt.sync_clr_i) begin
            r_hcount      <= c_H_LAST;
            r_vcount      <= c_V_LAST;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_vblank      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else if (vt.en_i) begin
            r_hcount      <= w_hnext;
            r_vcount      <= w_vnext;
            r_hsync       <= w_hs_region ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_region ? VS_POL : ~VS_POL;
            r_de          <= (w_hnext < c_H_ACT) && (w_vnext < c_V_ACT);
            r_vblank      <= (w_vnext >= c_V_ACT);
            r_line_start  <= (w_hnext == '0);
            r_frame_start <= (w_hnext == '0) && (w_vnext == '0);
            r_frame_end   <= (w_hnext == c_FE_H) && (w_vnext == c_FE_V);
        end else begin
            // Counts hold, so a strobe must not repeat.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end
    end

    assign vt.hcount_o      = r_hcount;
    assign vt.vcount_o      = r_vcount;
    assign vt.hsync_o       = r_hsync;
    assign vt.vsync_o       = r_vsync;
    assign vt.de_o          = r_de;
    assign vt.vblank_o      = r_vblank;
    assign vt.line_start_o  = r_line_start;
    assign vt.frame_start_o = r_frame_start;
    assign vt.frame_end_o   = r_frame_end;
endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen against a raster
//               position model derived from an enabled-tick count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: enabled ticks since reset/clear, and whether the last edge advanced.
    int k_s = 0, k_d = 0, k_v = 0;
    bit t_s = 0, t_d = 0, t_v = 0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(4))  bus_s ();
    video_timing_gen_if #(.CW(12)) bus_d ();
    video_timing_gen_if #(.CW(12)) bus_v ();

    video_timing_gen #(
        .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_s (.clk_i(clk), .rst_ni(rst_n), .vt(bus_s));

    video_timing_gen u_dut_d (.clk_i(clk), .rst_ni(rst_n), .vt(bus_d));

    video_timing_gen #(
        .CW(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_v (.clk_i(clk), .rst_ni(rst_n), .vt(bus_v));

    // Packed layout: {h[11:0], v[11:0], hs, vs, de, vb, ls, fs, fe}
    function automatic logic [30:0] model(int k, bit t, int ha, int hf, int hsw, int hb,
                                          int va, int vf, int vsw, int vbp, bit hp, bit vp);
        int   ht, vt, p, h, v;
        logic hs, vs, de, vb, ls, fs, fe;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vbp;
        if (k == 0) begin
            h = ht - 1;
            v = vt - 1;
        end else begin
            p = (k - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
        end
        hs = (k != 0 && h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        vs = (k != 0 && v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        de = (h < ha) && (v < va);
        vb = (v >= va);
        ls = t && (h == 0);
        fs = ls && (v == 0);
        fe = t && (h == ha - 1) && (v == va - 1);
        return {12'(h), 12'(v), hs, vs, de, vb, ls, fs, fe};
    endfunction

    function automatic logic [30:0] exp_s();
        return model(k_s, t_s, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    endfunction
    function automatic logic [30:0] exp_d();
        return model(k_d, t_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction
    function automatic logic [30:0] exp_v();
        return model(k_v, t_v, 4, 1, 2, 1, 480, 10, 2, 33, 1'b1, 1'b1);
    endfunction

    function automatic logic [30:0] obs_s();
        return {8'd0, bus_s.hcount_o, 8'd0, bus_s.vcount_o, bus_s.hsync_o, bus_s.vsync_o,
                bus_s.de_o, bus_s.vblank_o, bus_s.line_start_o, bus_s.frame_start_o,
                bus_s.frame_end_o};
    endfunction
    function automatic logic [30:0] obs_d();
        return {bus_d.hcount_o, bus_d.vcount_o, bus_d.hsync_o, bus_d.vsync_o,
                bus_d.de_o, bus_d.vblank_o, bus_d.line_start_o, bus_d.frame_start_o,
                bus_d.frame_end_o};
    endfunction
    function automatic logic [30:0] obs_v();
        return {bus_v.hcount_o, bus_v.vcount_o, bus_v.hsync_o, bus_v.vsync_o,
                bus_v.de_o, bus_v.vblank_o, bus_v.line_start_o, bus_v.frame_start_o,
                bus_v.frame_end_o};
    endfunction

    // Drive one cycle of inputs, then advance the model; returns at posedge+1.
    task automatic step(input bit es, input bit cs, input bit ed, input bit ev);
        bus_s.en_i = es;  bus_s.sync_clr_i = cs;
        bus_d.en_i = ed;  bus_d.sync_clr_i = 1'b0;
        bus_v.en_i = ev;  bus_v.sync_clr_i = 1'b0;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (cs) begin k_s = 0; t_s = 0; end
            else if (es) begin k_s++; t_s = 1; end
            else t_s = 0;
            if (ed) begin k_d++; t_d = 1; end else t_d = 0;
            if (ev) begin k_v++; t_v = 1; end else t_v = 0;
        end
    endtask

    task automatic test_reset();
        logic [30:0] g, e;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL reset_s cyc=%0d got=%h exp=%h", c, g, e); end
            g = obs_d(); e = exp_d(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL reset_d cyc=%0d got=%h exp=%h", c, g, e); end
            g = obs_v(); e = exp_v(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL reset_v cyc=%0d got=%h exp=%h", c, g, e); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_line();
        logic [30:0] g, e;
        logic [11:0] eh, ev;
        bit          ehs, ede, els;
        for (int c = 1; c <= 9; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL first_line cyc=%0d got=%h exp=%h", c, g, e); end
            eh  = 12'((c - 1) % 8);
            ev  = (c == 9) ? 12'd1 : 12'd0;
            ehs = !(c == 6 || c == 7);
            ede = (c <= 4) || (c == 9);
            els = (c == 1) || (c == 9);
            vectors++;
            if ({g[30:19], g[18:7], g[6], g[4], g[2]} !== {eh, ev, ehs, ede, els}) begin
                miscompares++;
                $display("FAIL first_line_fixed cyc=%0d got h=%0d v=%0d hs=%b de=%b ls=%b req h=%0d v=%0d hs=%b de=%b ls=%b",
                         c, g[30:19], g[18:7], g[6], g[4], g[2], eh, ev, ehs, ede, els);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [30:0] g, e;
        int fe_cnt = 0, vs_low = 0, vb_rise = 0;
        int fs_at[$];
        bit prev_vb = 1'b0;
        for (int i = 1; i <= 96; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL full_frame i=%0d got=%h exp=%h", i, g, e); end
            if (i <= 48) begin
                if (g[0]) fe_cnt++;
                if (!g[5]) vs_low++;
                if (g[3] && !prev_vb) begin
                    vb_rise++;
                    vectors++;
                    if (g[18:7] !== 12'd3) begin
                        miscompares++; $display("FAIL vblank_rise got v=%0d req v=3", g[18:7]);
                    end
                end
            end
            prev_vb = g[3];
            if (g[1]) fs_at.push_back(i);
        end
        vectors++;
        if (fe_cnt != 1) begin miscompares++; $display("FAIL frame_end_count got=%0d req=1", fe_cnt); end
        vectors++;
        if (vs_low != 8) begin miscompares++; $display("FAIL vsync_low_cycles got=%0d req=8", vs_low); end
        vectors++;
        if (vb_rise != 1) begin miscompares++; $display("FAIL vblank_rises got=%0d req=1", vb_rise); end
        vectors++;
        if (fs_at.size() != 2 || (fs_at[1] - fs_at[0]) != 48) begin
            miscompares++;
            $display("FAIL frame_start_period got pulses=%0d req pulses=2 period 48", fs_at.size());
        end
    endtask

    task automatic test_random_enable();
        logic [30:0] g, e;
        int  ticks = 0, intervals = 0;
        bit  seen = 1'b0, en;
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom_range(0, 1));
            step(en, 1'b0, 1'b0, 1'b0);
            if (en) ticks++;
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL random_enable i=%0d en=%b got=%h exp=%h", i, en, g, e); end
            if (g[1]) begin
                if (seen) begin
                    intervals++;
                    vectors++;
                    if (ticks != 48) begin
                        miscompares++; $display("FAIL frame_ticks got=%0d req=48", ticks);
                    end
                end
                seen  = 1'b1;
                ticks = 0;
            end
        end
        vectors++;
        if (intervals == 0) begin miscompares++; $display("FAIL frame_intervals got=0 req>=1"); end
    endtask

    task automatic test_sync_clear();
        logic [30:0] g, e;
        int n = 0;
        e = exp_s();
        while (!(e[30:19] == 12'd2 && e[18:7] == 12'd1) && n < 60) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = exp_s();
            n++;
        end
        g = obs_s(); vectors++;
        if (g !== e) begin miscompares++; $display("FAIL clr_reach n=%0d got=%h exp=%h", n, g, e); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        g = obs_s(); vectors++;
        if (g !== {12'd7, 12'd5, 7'b1101000}) begin
            miscompares++; $display("FAIL clr_load got=%h req=%h", g, {12'd7, 12'd5, 7'b1101000});
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL clr_hold cyc=%0d got=%h exp=%h", c, g, e); end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        g = obs_s(); vectors++;
        if (g !== {12'd0, 12'd0, 7'b1110110}) begin
            miscompares++; $display("FAIL clr_restart got=%h req=%h", g, {12'd0, 12'd0, 7'b1110110});
        end
    endtask

    task automatic test_async_reset();
        logic [30:0] g, e;
        int n = 0;
        e = exp_s();
        while (!(e[30:19] == 12'd5 && e[18:7] == 12'd4) && n < 60) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = exp_s();
            n++;
        end
        g = obs_s(); vectors++;
        if (g !== e) begin miscompares++; $display("FAIL arst_reach n=%0d got=%h exp=%h", n, g, e); end
        #2;
        rst_n = 1'b0;
        k_s = 0; t_s = 0; k_d = 0; t_d = 0; k_v = 0; t_v = 0;
        #1;
        g = obs_s(); vectors++;
        if (g !== {12'd7, 12'd5, 7'b1101000}) begin
            miscompares++; $display("FAIL arst_immediate got=%h req=%h", g, {12'd7, 12'd5, 7'b1101000});
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        g = obs_s(); e = exp_s(); vectors++;
        if (g !== e) begin miscompares++; $display("FAIL arst_hold got=%h exp=%h", g, e); end
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            g = obs_s(); e = exp_s(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL arst_recover cyc=%0d got=%h exp=%h", c, g, e); end
        end
    endtask

    task automatic test_default_timing();
        logic [30:0] g, e;
        int hs_low = 0, hs_first = -1, hs_last = -1;
        int vs_act = 0, vs_first_v = -1, vs_first_h = -1;
        for (int i = 1; i <= 4300; i++) begin
            step(1'b0, 1'b0, (i <= 1700), 1'b1);
            if (i <= 1700) begin
                g = obs_d(); e = exp_d(); vectors++;
                if (g !== e) begin miscompares++; $display("FAIL default_raster i=%0d got=%h exp=%h", i, g, e); end
                if (i <= 800 && !g[6]) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(g[30:19]);
                    hs_last = int'(g[30:19]);
                end
            end
            g = obs_v(); e = exp_v(); vectors++;
            if (g !== e) begin miscompares++; $display("FAIL vert_raster i=%0d got=%h exp=%h", i, g, e); end
            if (i <= 4200 && g[5]) begin
                vs_act++;
                if (vs_first_v < 0) begin vs_first_v = int'(g[18:7]); vs_first_h = int'(g[30:19]); end
            end
        end
        vectors++;
        if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
            miscompares++;
            $display("FAIL default_hsync got len=%0d first=%0d last=%0d req len=96 first=656 last=751",
                     hs_low, hs_first, hs_last);
        end
        vectors++;
        if (vs_act != 16 || vs_first_v != 490 || vs_first_h != 0) begin
            miscompares++;
            $display("FAIL default_vsync got cycles=%0d first_v=%0d first_h=%0d req cycles=16 first_v=490 first_h=0",
                     vs_act, vs_first_v, vs_first_h);
        end
    endtask

    initial begin
        bus_s.en_i = 1'b0; bus_s.sync_clr_i = 1'b0;
        bus_d.en_i = 1'b0; bus_d.sync_clr_i = 1'b0;
        bus_v.en_i = 1'b0; bus_v.sync_clr_i = 1'b0;
        test_reset();
        test_first_line();
        test_full_frame();
        test_random_enable();
        test_sync_clear();
        test_async_reset();
        test_default_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
